counter_down_c: RTL and testbench

Loadable down-counter/timer with a start/stop control handshake and a registered terminal-count pulse. It is the count-down complement of the team's up-counting loadable counter, and it serves as the countdown/timeout engine for bus-timeout, delay-slot and refresh timers. A reload register holds the programmed period so the counter can restart without reprogramming.

---
 rtl/counter_down_c.sv | 142 ++++++++++++++
 tb/tb_counter_down_c.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_down_c.sv
// -----------------------------------------------------------------------------
// counter_down_c
//   Loadable down-counter / timer with start/stop control and a registered
//   one-cycle terminal-count pulse. A reload register keeps the programmed
//   period, so a finished count can be restarted with a bare start.
//
//   Optional feature macro: COUNTER_DOWN_AUTO_RELOAD_EN
//     defined   : the terminal tick reloads D_OUT from the reload register and
//                 stays in RUN (periodic tc every RLD ticks).
//     undefined : one-shot; the terminal tick drives D_OUT to 0 and enters DONE.
//
// Ports
//   clk    : clock, all state changes on posedge
//   reset  : asynchronous, active-high; clears all state immediately
//   load   : write D_IN into the counter and the reload register (-> IDLE)
//   D_IN   : load value
//   start  : request counting (IDLE/DONE -> RUN)
//   stop   : pause counting (RUN -> IDLE, value held)
//   tick   : count enable, one decrement per tick cycle while in RUN
//   D_OUT  : current count value (registered)
//   tc     : terminal-count pulse, one cycle wide (registered)
//   busy   : high while in RUN (registered)
//   done   : high while in DONE (registered)
// -----------------------------------------------------------------------------
module counter_down_c #(
  parameter int word_width = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [word_width-1:0] D_IN,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  tick,
  output logic [word_width-1:0] D_OUT,
  output logic                  tc,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [word_width-1:0] ONE = {{(word_width-1){1'b0}}, 1'b1};

  state_t                state;
  logic [word_width-1:0] rld;

  state_t                nxt_state;
  logic [word_width-1:0] nxt_cnt;
  logic [word_width-1:0] nxt_rld;
  logic                  nxt_tc;

  // Decrement that saturates at zero instead of wrapping to all-ones.
  function automatic logic [word_width-1:0] dec_sat(input logic [word_width-1:0] v);
    return (v == '0) ? '0 : v - ONE;
  endfunction

  // Next-state / next-value decode. Priority: load > stop > start > tick.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = D_OUT;
    nxt_rld   = rld;
    nxt_tc    = 1'b0;
    if (load) begin
      nxt_cnt   = D_IN;
      nxt_rld   = D_IN;
      nxt_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // stop outranks start, so a simultaneous stop keeps us idle.
          if (!stop && start) begin
            if (D_OUT != '0) begin
              nxt_state = RUN;
            end else begin
              nxt_state = DONE;
              nxt_tc    = 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            nxt_state = IDLE;
          end else if (tick) begin
            if (D_OUT > ONE) begin
              nxt_cnt = dec_sat(D_OUT);
            end else begin
              // Terminal tick (D_OUT==1). RUN is never entered with a zero
              // count, so the "<= 1" branch only ever sees the value 1.
              nxt_tc = 1'b1;
`ifdef COUNTER_DOWN_AUTO_RELOAD_EN
              nxt_cnt = rld;
`else
              nxt_cnt   = '0;
              nxt_state = DONE;
`endif
            end
          end
        end
        DONE: begin
          // stop and tick have no meaning once finished; only start acts.
          if (start) begin
            if (rld != '0) begin
              nxt_cnt   = rld;
              nxt_state = RUN;
            end else begin
              nxt_tc = 1'b1;
            end
          end
        end
        default: begin
          nxt_state = IDLE;
        end
      endcase
    end
  end

  // State and output registers; busy/done are decoded from the next state so
  // they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      D_OUT <= '0;
      rld   <= '0;
      tc    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt_state;
      D_OUT <= nxt_cnt;
      rld   <= nxt_rld;
      tc    <= nxt_tc;
      busy  <= (nxt_state == RUN);
      done  <= (nxt_state == DONE);
    end
  end

endmodule

// File: tb/tb_counter_down_c.sv
module tb_counter_down_c;

  logic       clk = 1'b0;
  logic       reset;
  // 8-bit instance
  logic       ld8, st8, sp8, tk8;
  logic [7:0] din8, q8;
  logic       tc8, b8, d8;
  // 4-bit instance
  logic       ld4, st4, sp4, tk4;
  logic [3:0] din4, q4;
  logic       tc4, b4, d4;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  counter_down_c #(.word_width(8)) dut8 (
    .clk(clk), .reset(reset), .load(ld8), .D_IN(din8), .start(st8),
    .stop(sp8), .tick(tk8), .D_OUT(q8), .tc(tc8), .busy(b8), .done(d8)
  );

  counter_down_c #(.word_width(4)) dut4 (
    .clk(clk), .reset(reset), .load(ld4), .D_IN(din4), .start(st4),
    .stop(sp4), .tick(tk4), .D_OUT(q4), .tc(tc4), .busy(b4), .done(d4)
  );

  typedef struct {
    logic       ld;
    logic [7:0] din;
    logic       st, sp, tk;
    logic [7:0] q;
    logic       tc, b, d;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] q;
    logic       tc, b, d;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string nm, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  task automatic add(input logic ld, input logic [7:0] din, input logic st, input logic sp,
                     input logic tk, input logic [7:0] q, input logic tc_e, input logic b_e,
                     input logic d_e);
    vec_t v;
    v.ld = ld; v.din = din; v.st = st; v.sp = sp; v.tk = tk;
    v.q = q; v.tc = tc_e; v.b = b_e; v.d = d_e;
    tbl.push_back(v);
  endtask

  task automatic compare(input string tag, input logic [7:0] q, input logic t,
                         input logic b, input logic d);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk($sformatf("%s%0d.q", tag, e.id), int'(q), int'(e.q));
      chk($sformatf("%s%0d.tc", tag, e.id), int'(t), int'(e.tc));
      chk($sformatf("%s%0d.busy", tag, e.id), int'(b), int'(e.b));
      chk($sformatf("%s%0d.done", tag, e.id), int'(d), int'(e.d));
    end
  endtask

  // Drive one cycle on the 8-bit instance and compare after the edge.
  task automatic step8(input int id, input logic ld, input logic [7:0] din, input logic st,
                       input logic sp, input logic tk, input logic [7:0] q, input logic tc_e,
                       input logic b_e, input logic d_e);
    ld8 = ld; din8 = din; st8 = st; sp8 = sp; tk8 = tk;
    sb.push_back('{id, q, tc_e, b_e, d_e});
    @(posedge clk); #1;
    ld8 = 0; st8 = 0; sp8 = 0; tk8 = 0;
    compare("w8_", q8, tc8, b8, d8);
  endtask

  task automatic step4(input int id, input logic ld, input logic [3:0] din, input logic st,
                       input logic tk, input logic [3:0] q, input logic tc_e,
                       input logic b_e, input logic d_e);
    ld4 = ld; din4 = din; st4 = st; sp4 = 0; tk4 = tk;
    sb.push_back('{id, {4'd0, q}, tc_e, b_e, d_e});
    @(posedge clk); #1;
    ld4 = 0; st4 = 0; tk4 = 0;
    compare("w4_", {4'd0, q4}, tc4, b4, d4);
  endtask

  initial begin
    reset = 1'b1;
    ld8 = 0; din8 = 0; st8 = 0; sp8 = 0; tk8 = 0;
    ld4 = 0; din4 = 0; st4 = 0; sp4 = 0; tk4 = 0;
    #12;
    chk("rst.q", int'(q8), 0);
    chk("rst.tc", int'(tc8), 0);
    chk("rst.busy", int'(b8), 0);
    chk("rst.done", int'(d8), 0);
    chk("rst.q4", int'(q4), 0);
    @(posedge clk); #1;
    reset = 1'b0;

`ifndef COUNTER_DOWN_AUTO_RELOAD_EN
    //   ld din   st sp tk   q   tc b d
    // one-shot: tick held from the start cycle (ignored in IDLE)
    add(1, 8'd3,  0, 0, 0,  8'd3, 0, 0, 0);
    add(0, 8'd0,  1, 0, 1,  8'd3, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd2, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd1, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd0, 1, 0, 1);
    add(0, 8'd0,  0, 0, 1,  8'd0, 0, 0, 1);
    add(0, 8'd0,  0, 0, 1,  8'd0, 0, 0, 1);
    // pause / resume / priority
    add(1, 8'd10, 0, 0, 0,  8'd10, 0, 0, 0);
    add(0, 8'd0,  1, 0, 0,  8'd10, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd9, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd8, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd7, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd6, 0, 1, 0);
    add(0, 8'd0,  1, 1, 1,  8'd6, 0, 0, 0);
    add(0, 8'd0,  1, 0, 0,  8'd6, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd5, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd4, 0, 1, 0);
    add(1, 8'd7,  1, 0, 1,  8'd7, 0, 0, 0);
    add(0, 8'd0,  0, 0, 1,  8'd7, 0, 0, 0);
    // zero load
    add(1, 8'd0,  0, 0, 0,  8'd0, 0, 0, 0);
    add(0, 8'd0,  1, 0, 0,  8'd0, 1, 0, 1);
    add(0, 8'd0,  0, 0, 0,  8'd0, 0, 0, 1);
    add(0, 8'd0,  1, 0, 0,  8'd0, 1, 0, 1);
    add(0, 8'd0,  0, 0, 0,  8'd0, 0, 0, 1);
    // run to DONE and restart from reload register
    add(1, 8'd4,  0, 0, 0,  8'd4, 0, 0, 0);
    add(0, 8'd0,  1, 0, 0,  8'd4, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd3, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd2, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd1, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd0, 1, 0, 1);
    add(0, 8'd0,  1, 0, 0,  8'd4, 0, 1, 0);
    // gapped ticks 1010...
    add(0, 8'd0,  0, 0, 1,  8'd3, 0, 1, 0);
    add(0, 8'd0,  0, 0, 0,  8'd3, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd2, 0, 1, 0);
    add(0, 8'd0,  0, 0, 0,  8'd2, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd1, 0, 1, 0);
    add(0, 8'd0,  0, 0, 0,  8'd1, 0, 1, 0);
    add(0, 8'd0,  0, 0, 1,  8'd0, 1, 0, 1);
    add(0, 8'd0,  0, 0, 0,  8'd0, 0, 0, 1);
    // stop and tick ignored in DONE
    add(0, 8'd0,  0, 1, 1,  8'd0, 0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      step8(i, tbl[i].ld, tbl[i].din, tbl[i].st, tbl[i].sp, tbl[i].tk,
            tbl[i].q, tbl[i].tc, tbl[i].b, tbl[i].d);
    end
`endif

    // Asynchronous reset in the middle of a run, between clock edges.
    step8(100, 1, 8'd5, 0, 0, 0, 8'd5, 0, 0, 0);
    step8(101, 0, 8'd0, 1, 0, 0, 8'd5, 0, 1, 0);
    step8(102, 0, 8'd0, 0, 0, 1, 8'd4, 0, 1, 0);
    step8(103, 0, 8'd0, 0, 0, 1, 8'd3, 0, 1, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.q", int'(q8), 0);
    chk("arst.tc", int'(tc8), 0);
    chk("arst.busy", int'(b8), 0);
    chk("arst.done", int'(d8), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    // Reload register must also be cleared: DONE + start gives tc, no restart.
    step8(104, 0, 8'd0, 1, 0, 0, 8'd0, 1, 0, 1);
    step8(105, 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 1);
    step8(106, 0, 8'd0, 1, 0, 0, 8'd0, 1, 0, 1);
    step8(107, 0, 8'd0, 0, 0, 0, 8'd0, 0, 0, 1);

    // Width edge on the 4-bit instance: full-scale count.
    step4(200, 1, 4'd15, 0, 0, 4'd15, 0, 0, 0);
    step4(201, 0, 4'd0, 1, 0, 4'd15, 0, 1, 0);
    for (int i = 1; i <= 15; i++) begin
`ifdef COUNTER_DOWN_AUTO_RELOAD_EN
      if (i == 15) step4(201 + i, 0, 4'd0, 0, 1, 4'd15, 1, 1, 0);
      else         step4(201 + i, 0, 4'd0, 0, 1, 4'(15 - i), 0, 1, 0);
`else
      if (i == 15) step4(201 + i, 0, 4'd0, 0, 1, 4'd0, 1, 0, 1);
      else         step4(201 + i, 0, 4'd0, 0, 1, 4'(15 - i), 0, 1, 0);
`endif
    end
`ifdef COUNTER_DOWN_AUTO_RELOAD_EN
    step4(217, 0, 4'd0, 0, 1, 4'd14, 0, 1, 0);
`else
    step4(217, 0, 4'd0, 0, 1, 4'd0, 0, 0, 1);
`endif

`ifdef COUNTER_DOWN_AUTO_RELOAD_EN
    // Periodic reload with period 3.
    step8(300, 1, 8'd3, 0, 0, 0, 8'd3, 0, 0, 0);
    step8(301, 0, 8'd0, 1, 0, 0, 8'd3, 0, 1, 0);
    for (int i = 1; i <= 9; i++) begin
      if (i % 3 == 0) step8(301 + i, 0, 8'd0, 0, 0, 1, 8'd3, 1, 1, 0);
      else            step8(301 + i, 0, 8'd0, 0, 0, 1, 8'(3 - (i % 3)), 0, 1, 0);
    end
    // Period 1: tc on every tick cycle.
    step8(320, 1, 8'd1, 0, 0, 0, 8'd1, 0, 0, 0);
    step8(321, 0, 8'd0, 1, 0, 0, 8'd1, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step8(322 + i, 0, 8'd0, 0, 0, 1, 8'd1, 1, 1, 0);
    end
    step8(325, 0, 8'd0, 0, 0, 0, 8'd1, 0, 1, 0);
`endif

    chk("sb.drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
